clock_set_ctrl: RTL and testbench
=================================

// Module: clock_set_ctrl
// PURPOSE
//  Mode/sequencing controller for the HH:MM:SS time-of-day counter. Generates the 1 Hz tick enable,
//  runs a RUN/SET state machine from two pushbuttons, and loads an edited hour/minute into the counter.
//  Sits between the board keys and the time counter; the counter reads tick_sec and load_* only.
// PARAMETERS
//  TICK_DIV    50000000  clk cycles per second tick (>=2); bench uses 5
//  PRE_W       26        prescaler width; must hold TICK_DIV-1
// PORTS
//  clk         in   1      system clock, all logic on rising edge
//  resetN      in   1      asynchronous, active-low reset
//  startN      in   1      active-low start level (synchronous)
//  modeN       in   1      active-low MODE key, asynchronous to clk
//  incN        in   1      active-low INC key, asynchronous to clk
//  cur_hour    in   5      current hour from time counter (0..23)
//  cur_min     in   6      current minute from time counter (0..59)
//  cur_sec     in   6      current second from time counter (0..59)
//  alarm_hour  in   5      alarm hour (used only with ALARM_EN)
//  alarm_min   in   6      alarm minute (used only with ALARM_EN)
//  alarm_on    in   1      alarm enable (used only with ALARM_EN)
//  tick_sec    out  1      1-cycle pulse: advance counter by one second
//  load_en     out  1      1-cycle pulse: counter loads load_hour/load_min/load_sec
//  load_hour   out  5      hour to load
//  load_min    out  6      minute to load
//  load_sec    out  6      second to load (always 0)
//  set_field   out  2      00 none, 01 editing hour, 10 editing minute
//  blink       out  1      display blink for edited field
//  alarm       out  1      1-cycle alarm pulse
// BEHAVIOUR
//  - Reset: state=IDLE, prescaler=0, edit regs=0, sync flops=1 (released); all outputs 0.
//  - Keys: 2-flop sync, then falling-edge detect -> press pulse 3 cycles after pin edge; held key = one press.
//  - States: IDLE, RUN, SET_HOUR, SET_MIN, APPLY.
//  - IDLE: startN==0 sampled -> RUN next cycle; prescaler held at 0; key presses ignored.
//  - RUN: prescaler 0..TICK_DIV-1, wraps to 0; tick_sec=1 in the cycle prescaler==TICK_DIV-1.
//    First tick after entering RUN occurs TICK_DIV cycles after entry.
//    MODE press -> SET_HOUR; same edge captures edit_hour<=cur_hour, edit_min<=cur_min.
//    INC press in RUN ignored.
//  - SET_HOUR: INC -> edit_hour+1, 23 wraps to 0. MODE -> SET_MIN. set_field=01.
//  - SET_MIN: INC -> edit_min+1, 59 wraps to 0. MODE -> APPLY. set_field=10.
//  - SET states: tick_sec forced 0; prescaler keeps counting; blink toggles on each prescaler wrap.
//  - APPLY (exactly 1 cycle): load_en=1, load_hour=edit_hour, load_min=edit_min, load_sec=0.
//    Prescaler cleared to 0; next state RUN. No tick_sec in the APPLY cycle.
//  - load_hour/load_min hold edit values outside APPLY; load_sec constant 0.
//  - blink and set_field are 0 in IDLE/RUN/APPLY; blink cleared on entry to SET_HOUR.
//  - MODE and INC press in the same cycle: MODE wins, INC dropped.
//  - startN ignored outside IDLE. No path returns to IDLE except resetN.
//  - resetN low mid-edit: edits discarded, no load_en, IDLE immediately (async).
// CONFIGURATION
//  CLOCK_ALARM_EN defined:
//    - alarm=1 for one cycle in RUN when alarm_on=1 and cur_hour==alarm_hour,
//      cur_min==alarm_min, cur_sec==0.
//    - Fires on the rising edge of this match condition only, so it is not repeated while the match holds.
//    - Suppressed in SET/APPLY states.
//    - A match already true on entry to RUN does not fire.
//  CLOCK_ALARM_EN undefined: alarm tied to 0; alarm_* inputs unused; all ports stay present.
// TESTING
//  - TICK_DIV=5, reset, startN=0 -> RUN; tick_sec pulses every 5 cycles, first 5 cycles after RUN entry.
//  - RUN with cur=10:20:xx, MODE -> set_field=01, then INC x14 -> edit_hour=0 (wrap at 24).
//    Then MODE -> set_field=10; INC x40 -> edit_min=0 (wrap from 59).
//    Then MODE -> one cycle load_en=1, load_hour=0, load_min=0, load_sec=0; RUN follows.
//  - MODE and INC pressed in the same cycle in SET_HOUR -> SET_MIN, edit_hour unchanged.
//    INC held 100 cycles -> exactly one increment.
//  - resetN pulsed low during SET_MIN -> all outputs 0, IDLE, load_en never asserted.
//  - CLOCK_ALARM_EN, alarm=07:30, alarm_on=1, cur_sec stepping 59->0 at 07:30 -> exactly one alarm pulse.
//    Same stimulus with alarm_on=0 -> no alarm pulse.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// RUN/SET mode controller for the HH:MM:SS counter: 1 Hz tick, key-driven hour/minute edit and load.
// Optional alarm pulse compiled in when CLOCK_ALARM_EN is defined.
module clock_set_ctrl #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned PRE_W    = 26
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startN,
  input  logic       modeN,
  input  logic       incN,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  input  logic [4:0] alarm_hour,
  input  logic [5:0] alarm_min,
  input  logic       alarm_on,
  output logic       tick_sec,
  output logic       load_en,
  output logic [4:0] load_hour,
  output logic [5:0] load_min,
  output logic [5:0] load_sec,
  output logic [1:0] set_field,
  output logic       blink,
  output logic       alarm
);

  typedef enum logic [2:0] {IDLE, RUN, SET_HOUR, SET_MIN, APPLY} state_t;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  state_t           state, nstate;
  logic [PRE_W-1:0] pre;
  logic [4:0]       edit_hour;
  logic [5:0]       edit_min;
  logic [2:0]       mode_sync, inc_sync;
  logic             mode_press, inc_press;
  logic             wrap, in_set, next_in_set;
  logic             blink_q;

  // Bits [1:0] synchronise the pin, bit 2 is the previous synchronised level.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      mode_sync <= '1;
      inc_sync  <= '1;
    end else begin
      mode_sync <= {mode_sync[1:0], modeN};
      inc_sync  <= {inc_sync[1:0], incN};
    end
  end

  assign mode_press  = mode_sync[2] & ~mode_sync[1];
  assign inc_press   = inc_sync[2] & ~inc_sync[1] & ~mode_press;
  assign wrap        = (pre == PRE_LAST);
  assign in_set      = (state == SET_HOUR) || (state == SET_MIN);
  assign next_in_set = (nstate == SET_HOUR) || (nstate == SET_MIN);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:     if (!startN)   nstate = RUN;
      RUN:      if (mode_press) nstate = SET_HOUR;
      SET_HOUR: if (mode_press) nstate = SET_MIN;
      SET_MIN:  if (mode_press) nstate = APPLY;
      APPLY:    nstate = RUN;
      default:  nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)                             pre <= '0;
    else if (state == IDLE || state == APPLY) pre <= '0;
    else if (wrap)                           pre <= '0;
    else                                     pre <= pre + 1'b1;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      edit_hour <= '0;
      edit_min  <= '0;
    end else begin
      if (state == RUN && mode_press) begin
        edit_hour <= cur_hour;
        edit_min  <= cur_min;
      end
      if (state == SET_HOUR && inc_press)
        edit_hour <= (edit_hour == 5'd23) ? 5'd0 : edit_hour + 5'd1;
      if (state == SET_MIN && inc_press)
        edit_min <= (edit_min == 6'd59) ? 6'd0 : edit_min + 6'd1;
    end
  end

  // Blink runs only while staying inside the SET states, so it starts at 0 on entry and is 0 in APPLY.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)                    blink_q <= 1'b0;
    else if (in_set && next_in_set) blink_q <= blink_q ^ wrap;
    else                            blink_q <= 1'b0;
  end

  always_comb begin
    tick_sec  = (state == RUN) && wrap;
    load_en   = (state == APPLY);
    load_hour = edit_hour;
    load_min  = edit_min;
    load_sec  = '0;
    blink     = blink_q;
    set_field = 2'b00;
    case (state)
      SET_HOUR: set_field = 2'b01;
      SET_MIN:  set_field = 2'b10;
      default:  set_field = 2'b00;
    endcase
  end

`ifdef CLOCK_ALARM_EN
  logic match, match_q;

  assign match = alarm_on && (cur_hour == alarm_hour) && (cur_min == alarm_min) && (cur_sec == 6'd0);

  // match_q tracks in every state, so a match already present on entry to RUN has no rising edge.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) match_q <= 1'b0;
    else         match_q <= match;
  end

  assign alarm = (state == RUN) && match && !match_q;
`else
  logic unused_alarm;
  assign unused_alarm = ^{alarm_hour, alarm_min, alarm_on, cur_sec};
  assign alarm        = 1'b0;
`endif

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl with TICK_DIV=5; expected ticks and loads are queued and
// popped by a monitor when the DUT emits them.
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       resetN, startN, modeN, incN, alarm_on;
  logic [4:0] cur_hour, alarm_hour;
  logic [5:0] cur_min, cur_sec, alarm_min;
  logic       tick_sec, load_en, blink, alarm;
  logic [4:0] load_hour;
  logic [5:0] load_min, load_sec;
  logic [1:0] set_field;

  clock_set_ctrl #(.TICK_DIV(5), .PRE_W(3)) dut (
    .clk(clk), .resetN(resetN), .startN(startN), .modeN(modeN), .incN(incN),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .alarm_hour(alarm_hour), .alarm_min(alarm_min), .alarm_on(alarm_on),
    .tick_sec(tick_sec), .load_en(load_en), .load_hour(load_hour), .load_min(load_min),
    .load_sec(load_sec), .set_field(set_field), .blink(blink), .alarm(alarm)
  );

  always #5 clk = ~clk;

  int          nvec = 0;
  int          nerr = 0;
  int          cyc  = 0;
  int          alarm_cnt = 0;
  bit          tick_mon = 1'b0;
  int          tick_q[$];
  logic [10:0] load_q[$];
  logic [10:0] exp_ld;

`ifdef CLOCK_ALARM_EN
  localparam int ALARM_EXP = 1;
`else
  localparam int ALARM_EXP = 0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input bit m, input bit i);
    modeN = ~m;
    incN  = ~i;
    step(4);
    modeN = 1'b1;
    incN  = 1'b1;
    step(4);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {tick_sec, load_en, load_hour, load_min, load_sec, set_field, blink, alarm}, 0);
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (load_en) begin
      if (load_q.size() == 0) check("load_unexpected", 1, 0);
      else begin
        exp_ld = load_q.pop_front();
        check("load_hour", load_hour, exp_ld[10:6]);
        check("load_min", load_min, exp_ld[5:0]);
        check("load_sec", load_sec, 0);
        check("tick_in_apply", tick_sec, 0);
      end
    end
    if (tick_mon && tick_sec) begin
      if (tick_q.size() == 0) check("tick_unexpected", 1, 0);
      else check("tick_cycle", cyc, tick_q.pop_front());
    end
    if (alarm) alarm_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base, changes;
    logic prev;
    resetN = 1'b0; startN = 1'b1; modeN = 1'b1; incN = 1'b1;
    cur_hour = 5'd10; cur_min = 6'd20; cur_sec = 6'd1;
    alarm_hour = 5'd7; alarm_min = 6'd30; alarm_on = 1'b0;
    #3;
    check_all_zero("reset_outputs");
    step(2);
    resetN = 1'b1;
    step(3);

    // IDLE: no ticks, keys ignored
    tick_mon = 1'b1;
    press(1, 0);
    step(10);
    check("idle_set_field", set_field, 0);
    check("idle_no_capture", load_hour, 0);

    // RUN tick cadence
    startN = 1'b0;
    step(1);
    startN = 1'b1;
    base = cyc;
    tick_q.push_back(base + 4);
    tick_q.push_back(base + 9);
    tick_q.push_back(base + 14);
    step(15);
    check("tick_q_drained", tick_q.size(), 0);
    tick_mon = 1'b0;

    // enter SET_HOUR: capture 10:20, blink cleared
    modeN = 1'b0;
    step(3);
    check("sethour_field", set_field, 1);
    check("sethour_blink0", blink, 0);
    check("capture_hour", load_hour, 10);
    check("capture_min", load_min, 20);
    step(1);
    modeN = 1'b1;
    step(4);
    prev = blink; changes = 0;
    repeat (5) begin
      step(1);
      if (blink !== prev) changes++;
      prev = blink;
    end
    check("blink_toggle_per_wrap", changes, 1);

    repeat (13) press(0, 1);
    check("hour_23", load_hour, 23);
    press(0, 1);
    check("hour_wrap", load_hour, 0);

    press(1, 0);
    check("setmin_field", set_field, 2);
    repeat (39) press(0, 1);
    check("min_59", load_min, 59);
    press(0, 1);
    check("min_wrap", load_min, 0);

    load_q.push_back({5'd0, 6'd0});
    press(1, 0);
    check("apply_done", load_q.size(), 0);
    check("run_field", set_field, 0);
    check("run_blink", blink, 0);

    // MODE+INC together, then a held INC
    cur_hour = 5'd5; cur_min = 6'd7;
    press(1, 0);
    check("capture_hour2", load_hour, 5);
    press(1, 1);
    check("mode_wins_field", set_field, 2);
    check("mode_wins_hour", load_hour, 5);
    incN = 1'b0;
    step(100);
    incN = 1'b1;
    step(4);
    check("held_inc_once", load_min, 8);

    // async reset in SET_MIN: edits dropped, no load
    #2;
    resetN = 1'b0;
    #1;
    check_all_zero("midedit_reset");
    step(2);
    resetN = 1'b1;
    step(10);
    check("post_reset_idle", set_field, 0);
    check("post_reset_edit", load_hour, 0);
    check("no_load_pending", load_q.size(), 0);

    // alarm on second rollover at 07:30
    startN = 1'b0;
    step(1);
    startN = 1'b1;
    cur_hour = 5'd7; cur_min = 6'd30; cur_sec = 6'd59; alarm_on = 1'b1;
    step(3);
    alarm_cnt = 0;
    cur_sec = 6'd0;
    step(10);
    cur_sec = 6'd1;
    step(3);
    check("alarm_once", alarm_cnt, ALARM_EXP);

    alarm_on = 1'b0; cur_sec = 6'd59;
    step(3);
    alarm_cnt = 0;
    cur_sec = 6'd0;
    step(10);
    check("alarm_off", alarm_cnt, 0);

    // match already true at RUN entry must not fire
    resetN = 1'b0;
    step(2);
    resetN = 1'b1;
    alarm_on = 1'b1;
    step(3);
    alarm_cnt = 0;
    startN = 1'b0;
    step(1);
    startN = 1'b1;
    step(10);
    check("alarm_entry_match", alarm_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
